cpu_ecc_scrub_ctrl: RTL and testbench
=====================================

Name: cpu_ecc_scrub_ctrl

Overview:
Sits between a functional requester and one ECC single-port RAM shell. Runs a post-reset zero-initialisation sweep, then background scrubs: periodically reads one address and writes back corrected data on a single-bit error. Arbitrates the single memory port between functional traffic and scrub traffic, with functional priority and a bounded starvation guard.

Parameters:
DATA_W, 128, data width of the memory word
DEPTH, 1024, number of words
ADDR_W, $clog2(DEPTH), address width
RD_LAT, 1, fixed memory read latency in cycles (1..4)
SCRUB_INTV, 1024, cycles between scrub reads (>=RD_LAT+2)
STARVE_MAX, 16, max consecutive cycles a pending scrub op may be blocked

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_vld  in  1  functional request valid
req_rdy  out  1  functional request accepted this cycle
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_W  functional address
req_wdata  in  DATA_W  functional write data
rsp_vld  out  1  functional read data valid
rsp_rdata  out  DATA_W  functional read data (corrected)
rsp_err2b  out  1  uncorrectable error on this read
mem_ce  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  corrected read data, valid RD_LAT cycles after a read ce
mem_err1b  in  1  correctable error flag, aligned with mem_rdata
mem_err2b  in  1  uncorrectable error flag, aligned with mem_rdata
init_done  out  1  zero-initialisation complete
scrub_en  in  1  enable background scrubbing (quasi-static)
irq_err2b  out  1  one-cycle pulse on any uncorrectable error (functional or scrub)

Behaviour:
- Reset values: req_rdy=0, rsp_vld=0, rsp_rdata=0, rsp_err2b=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, init_done=0, irq_err2b=0; FSM=INIT, scrub pointer=0, interval counter=0, starve counter=0.
- States: INIT, IDLE, SCRB_RD, SCRB_WAIT, SCRB_WB.
- INIT: one write per cycle, addr 0..DEPTH-1, data 0; req_rdy=0. On writing DEPTH-1, go to IDLE and set init_done=1 the next cycle. init_done stays 1 until reset.
- Functional path (IDLE, SCRB_WAIT, and when scrub does not own the port): req_rdy=1 unless scrub owns the port this cycle. On req_vld&req_rdy, drive mem_ce=1 and mem_we=req_wr the same cycle (combinational pass-through). Read data returns as rsp_vld RD_LAT cycles later, in order, one per accepted read.
- Interval counter runs in IDLE only when scrub_en=1. At SCRUB_INTV-1 it raises scrub_pend.
- Scrub arbitration: scrub takes the port when req_vld=0 or starve counter==STARVE_MAX. The starve counter increments each cycle scrub_pend is blocked and clears when scrub is granted.
- SCRB_RD: one read cycle at the scrub pointer, with req_rdy=0. Then go to SCRB_WAIT for RD_LAT cycles; functional reads and writes are allowed there, and the read pipeline carries a scrub/functional tag.
- On the scrub response: if err1b, go to SCRB_WB; otherwise go to IDLE.
- SCRB_WB: write the captured corrected word to the same address, using the same arbitration rule as the read. Then go to IDLE.
- After each scrub op, the pointer increments and wraps DEPTH-1 -> 0. The interval counter restarts.
- Hazard rule: a functional write to the scrub address accepted between SCRB_RD and SCRB_WB cancels the write-back, so functional data wins.
- Error reporting: err2b on a scrub read means no write-back and a pulse on irq_err2b. err2b on a functional read sets rsp_err2b with rsp_vld and pulses irq_err2b.
- Simultaneous events: a scrub read and a functional write to the same address never occur in the same cycle (single port).
- scrub_en falling mid-op: the current op completes; no new op starts.
- Reset mid-operation: in-flight responses are dropped, and INIT restarts from address 0.

Optional Feature:
CPU_ECC_SCRUB_ERR_CNT_EN
- Defined: adds outputs err1b_cnt[15:0] and err2b_cnt[15:0]. These are saturating counts of scrub plus functional errors, reset to 0, cleared by a new input cnt_clr (a clear in the same cycle as an error yields 0).
- Undefined: the ports and counters are absent.

Decomposition:
- Package cpu_ecc_scrub_pkg holds the state enum (scrub_st_e) and the read-tag typedef (rd_tag_t: is_scrub, addr).
- One sub-module, cpu_ecc_scrub_rdpipe: an RD_LAT-deep shift register of the tag and valid bit, aligning responses with mem_rdata.

Test Plan:
- Reset release, DEPTH=16 -> 16 consecutive writes of 0, addr 0..15; init_done=1 at cycle 17; req_rdy=0 throughout.
- scrub_en=1, SCRUB_INTV=8, no traffic, mem_err1b forced on addr 3 -> read at addr 3, then a write of the returned rdata to addr 3; no write at other addresses.
- Continuous req_vld, STARVE_MAX=4, scrub pending -> scrub granted on the 5th blocked cycle; req_rdy=0 for exactly that cycle.
- Scrub reads addr 5 with err1b, functional write to addr 5 in SCRB_WAIT -> no write-back; a later read of addr 5 returns the functional data.
- Functional read with mem_err2b=1 -> rsp_vld, rsp_err2b=1, irq_err2b pulse, all RD_LAT cycles after acceptance.
- Pointer at DEPTH-1 after a scrub op -> the next scrub read is at addr 0; assert rst mid-SCRB_WAIT -> INIT restarts at addr 0 with no rsp_vld.

Source files
------------

// File: rtl/cpu_ecc_scrub_pkg.sv
// Shared types for the ECC scrub controller: FSM state encoding and the read-pipeline tag.
package cpu_ecc_scrub_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SCRB_RD,
        ST_SCRB_WAIT,
        ST_SCRB_WB
    } scrub_st_e;

    // Wide enough for any practical DEPTH; the top zero-extends its address into it.
    localparam int TAG_ADDR_W = 16;

    typedef struct packed {
        logic                  is_scrub;
        logic [TAG_ADDR_W-1:0] addr;
    } rd_tag_t;

endpackage

// File: rtl/cpu_ecc_scrub_ctrl_rdpipe.sv
// Fixed-latency shift register carrying valid + tag so each read response can be
// matched to its issuer when mem_rdata arrives.
module cpu_ecc_scrub_rdpipe
    import cpu_ecc_scrub_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    in_vld,
    input  rd_tag_t in_tag,
    output logic    out_vld,
    output rd_tag_t out_tag
);

    logic [RD_LAT-1:0] vld_q, vld_d;
    rd_tag_t           tag_q [RD_LAT];
    rd_tag_t           tag_d [RD_LAT];

    always_comb begin
        vld_d[0] = in_vld;
        tag_d[0] = in_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    // Valids are cleared by reset so in-flight responses are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign out_vld = vld_q[RD_LAT-1];
    assign out_tag = tag_q[RD_LAT-1];

endmodule

// File: rtl/cpu_ecc_scrub_ctrl.sv
// ECC scrub controller: zero-init sweep, then periodic read/correct/write-back scrubbing
// sharing one RAM port with functional traffic. CPU_ECC_SCRUB_ERR_CNT_EN adds error counters.
module cpu_ecc_scrub_ctrl
    import cpu_ecc_scrub_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int RD_LAT     = 1,
    parameter int SCRUB_INTV = 1024,
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_vld,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err2b,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err1b,
    input  logic              mem_err2b,
    output logic              init_done,
    input  logic              scrub_en,
    output logic              irq_err2b
`ifdef CPU_ECC_SCRUB_ERR_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       err1b_cnt,
    output logic [15:0]       err2b_cnt
`endif
);

    localparam int INTV_W = $clog2(SCRUB_INTV);
    localparam int STV_W  = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [INTV_W-1:0] INTV_LAST = INTV_W'(SCRUB_INTV - 1);
    localparam logic [STV_W-1:0]  STV_LIMIT = STV_W'(STARVE_MAX);

    scrub_st_e         st_q, st_d;
    logic              run_q;
    logic              init_done_q, init_done_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_next;
    logic [INTV_W-1:0] intv_q, intv_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              cancel_q, cancel_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              op_done;

    logic              scrub_gnt, func_acc, func_wr_hit, scrub_rsp;
    logic              pipe_in_vld, pipe_vld;
    rd_tag_t           pipe_in_tag, pipe_tag;
    logic              unused_tag;

    assign scrub_gnt   = (st_q == ST_SCRB_RD || st_q == ST_SCRB_WB) &&
                         (!req_vld || starve_q == STV_LIMIT);
    assign req_rdy     = run_q && (st_q != ST_INIT) && !scrub_gnt;
    assign func_acc    = req_vld && req_rdy;
    assign func_wr_hit = func_acc && req_wr && (req_addr == ptr_q);
    assign scrub_rsp   = pipe_vld && pipe_tag.is_scrub;
    assign ptr_next    = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);
    assign unused_tag  = ^pipe_tag.addr;

    // run_q holds the port quiet during reset and for the first cycle after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= ST_INIT;
            run_q       <= 1'b0;
            init_done_q <= 1'b0;
            ptr_q       <= '0;
            intv_q      <= '0;
            starve_q    <= '0;
            cancel_q    <= 1'b0;
            wb_addr_q   <= '0;
        end else begin
            st_q        <= st_d;
            run_q       <= 1'b1;
            init_done_q <= init_done_d;
            ptr_q       <= ptr_d;
            intv_q      <= intv_d;
            starve_q    <= starve_d;
            cancel_q    <= cancel_d;
            wb_addr_q   <= wb_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        wb_data_q <= wb_data_d;
    end

    always_comb begin
        wb_data_d = wb_data_q;
        if (st_q == ST_SCRB_WAIT && scrub_rsp) begin
            wb_data_d = mem_rdata;
        end
    end

    always_comb begin
        st_d        = st_q;
        init_done_d = init_done_q;
        ptr_d       = ptr_q;
        intv_d      = intv_q;
        starve_d    = starve_q;
        cancel_d    = cancel_q;
        wb_addr_d   = wb_addr_q;
        op_done     = 1'b0;
        case (st_q)
            ST_INIT: begin
                if (run_q) begin
                    ptr_d = ptr_next;
                    if (ptr_q == LAST_ADDR) begin
                        st_d        = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (scrub_en) begin
                    if (intv_q == INTV_LAST) begin
                        intv_d = '0;
                        st_d   = ST_SCRB_RD;
                    end else begin
                        intv_d = intv_q + INTV_W'(1);
                    end
                end
            end
            ST_SCRB_RD: begin
                cancel_d = 1'b0;
                if (scrub_gnt) begin
                    starve_d = '0;
                    st_d     = ST_SCRB_WAIT;
                end else begin
                    starve_d = starve_q + STV_W'(1);
                end
            end
            ST_SCRB_WAIT: begin
                if (func_wr_hit) begin
                    cancel_d = 1'b1;
                end
                // A functional write to the scrubbed word in the hazard window wins.
                if (scrub_rsp) begin
                    if (mem_err1b && !mem_err2b && !cancel_q && !func_wr_hit) begin
                        st_d      = ST_SCRB_WB;
                        wb_addr_d = pipe_tag.addr[ADDR_W-1:0];
                    end else begin
                        op_done = 1'b1;
                    end
                end
            end
            ST_SCRB_WB: begin
                if (func_wr_hit || scrub_gnt) begin
                    op_done = 1'b1;
                end else begin
                    starve_d = starve_q + STV_W'(1);
                end
            end
            default: st_d = ST_INIT;
        endcase
        if (op_done) begin
            st_d     = ST_IDLE;
            ptr_d    = ptr_next;
            intv_d   = '0;
            starve_d = '0;
        end
    end

    always_comb begin
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        pipe_in_vld = 1'b0;
        pipe_in_tag = '0;
        case (st_q)
            ST_INIT: begin
                if (run_q) begin
                    mem_ce   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = ptr_q;
                end
            end
            ST_SCRB_RD: begin
                if (scrub_gnt) begin
                    mem_ce               = 1'b1;
                    mem_addr             = ptr_q;
                    pipe_in_vld          = 1'b1;
                    pipe_in_tag.is_scrub = 1'b1;
                    pipe_in_tag.addr     = TAG_ADDR_W'(ptr_q);
                end
            end
            ST_SCRB_WB: begin
                if (scrub_gnt) begin
                    mem_ce    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wb_addr_q;
                    mem_wdata = wb_data_q;
                end
            end
            default: ;
        endcase
        if (func_acc) begin
            mem_ce               = 1'b1;
            mem_we               = req_wr;
            mem_addr             = req_addr;
            mem_wdata            = req_wr ? req_wdata : '0;
            pipe_in_vld          = !req_wr;
            pipe_in_tag.is_scrub = 1'b0;
            pipe_in_tag.addr     = TAG_ADDR_W'(req_addr);
        end
    end

    cpu_ecc_scrub_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (pipe_in_vld),
        .in_tag  (pipe_in_tag),
        .out_vld (pipe_vld),
        .out_tag (pipe_tag)
    );

    assign rsp_vld   = pipe_vld && !pipe_tag.is_scrub;
    assign rsp_rdata = rsp_vld ? mem_rdata : '0;
    assign rsp_err2b = rsp_vld && mem_err2b;
    assign irq_err2b = pipe_vld && mem_err2b;
    assign init_done = init_done_q;

`ifdef CPU_ECC_SCRUB_ERR_CNT_EN
    logic [15:0] err1b_cnt_q, err1b_cnt_d, err2b_cnt_q, err2b_cnt_d;

    always_comb begin
        err1b_cnt_d = err1b_cnt_q;
        err2b_cnt_d = err2b_cnt_q;
        if (cnt_clr) begin
            err1b_cnt_d = '0;
            err2b_cnt_d = '0;
        end else begin
            if (pipe_vld && mem_err1b && err1b_cnt_q != '1) err1b_cnt_d = err1b_cnt_q + 16'd1;
            if (pipe_vld && mem_err2b && err2b_cnt_q != '1) err2b_cnt_d = err2b_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err1b_cnt_q <= '0;
            err2b_cnt_q <= '0;
        end else begin
            err1b_cnt_q <= err1b_cnt_d;
            err2b_cnt_q <= err2b_cnt_d;
        end
    end

    assign err1b_cnt = err1b_cnt_q;
    assign err2b_cnt = err2b_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_ecc_scrub_ctrl.sv
// Directed bench for cpu_ecc_scrub_ctrl with a small RAM model and error injection.
module tb_cpu_ecc_scrub_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_vld, req_rdy, req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_vld, rsp_err2b;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_ce, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_err1b, mem_err2b;
    logic              init_done, scrub_en, irq_err2b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_ecc_scrub_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
        .SCRUB_INTV(8), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err2b(rsp_err2b),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_err1b(mem_err1b), .mem_err2b(mem_err2b),
        .init_done(init_done), .scrub_en(scrub_en), .irq_err2b(irq_err2b)
    );

    // RAM model: returns stored (already corrected) data with injected error flags.
    logic [DATA_W-1:0] mem_arr [DEPTH];
    logic [DATA_W-1:0] rdq [RD_LAT];
    logic              e1q [RD_LAT];
    logic              e2q [RD_LAT];
    logic [DEPTH-1:0]  e1_mask, e2_mask;

    typedef struct {
        bit          we;
        int unsigned addr;
        logic [31:0] data;
    } mev_t;
    mev_t mlog[$];

    always @(posedge clk) begin
        mev_t ev;
        if (mem_ce === 1'b1) begin
            ev.we   = mem_we;
            ev.addr = int'(mem_addr);
            ev.data = mem_wdata;
            mlog.push_back(ev);
        end
        if (mem_ce && mem_we) mem_arr[mem_addr] <= mem_wdata;
        rdq[0] <= (mem_ce && !mem_we) ? mem_arr[mem_addr] : 32'hDEAD_BEEF;
        e1q[0] <= mem_ce && !mem_we && e1_mask[mem_addr];
        e2q[0] <= mem_ce && !mem_we && e2_mask[mem_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            rdq[i] <= rdq[i-1];
            e1q[i] <= e1q[i-1];
            e2q[i] <= e2q[i-1];
        end
    end

    assign mem_rdata = rdq[RD_LAT-1];
    assign mem_err1b = e1q[RD_LAT-1];
    assign mem_err2b = e2q[RD_LAT-1];

    task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_rdy !== 1'b0 || mem_ce !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 ||
            mem_wdata !== '0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_port: rdy=%b ce=%b we=%b addr=%0d wdata=%h init_done=%b, all should be 0",
                     req_rdy, mem_ce, mem_we, mem_addr, mem_wdata, init_done);
        end
        checks++;
        if (rsp_vld !== 1'b0 || rsp_rdata !== '0 || rsp_err2b !== 1'b0 || irq_err2b !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: rsp_vld=%b rdata=%h err2b=%b irq=%b, all should be 0",
                     rsp_vld, rsp_rdata, rsp_err2b, irq_err2b);
        end
    endtask

    task automatic check_init_sweep(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_ce !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: mem_ce=%b in first cycle, expected 0", tag, mem_ce);
        end
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk); #1;
            checks++;
            if (mem_ce !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(k) || mem_wdata !== '0 ||
                req_rdy !== 1'b0 || init_done !== 1'b0 || rsp_vld !== 1'b0) begin
                errors++;
                $display("FAIL %s_wr%0d: ce=%b we=%b addr=%0d wdata=%h rdy=%b done=%b rsp_vld=%b, expected zero write to %0d, rdy=0 done=0 rsp_vld=0",
                         tag, k, mem_ce, mem_we, mem_addr, mem_wdata, req_rdy, init_done, rsp_vld, k);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (init_done !== 1'b1 || mem_ce !== 1'b0 || req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: init_done=%b ce=%b rdy=%b, expected 1 0 1", tag, init_done, mem_ce, req_rdy);
        end
    endtask

    task automatic test_init();
        check_init_sweep("init");
    endtask

    task automatic test_scrub_wb();
        bit          exp_we   [6] = '{0, 0, 0, 0, 1, 0};
        int unsigned exp_addr [6] = '{0, 1, 2, 3, 3, 4};
        int          n;
        do_req(1'b1, 4'd3, 32'h0000_3C3C);
        e1_mask[3] = 1'b1;
        mlog.delete();
        @(negedge clk);
        scrub_en = 1'b1;
        for (n = 0; n < 200 && mlog.size() < 6; n++) @(negedge clk);
        scrub_en = 1'b0;
        checks++;
        if (mlog.size() < 6) begin
            errors++;
            $display("FAIL scrub_timeout: %0d memory ops seen, expected 6", mlog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (mlog[i].we !== exp_we[i] || mlog[i].addr != exp_addr[i] ||
                    (exp_we[i] && mlog[i].data !== 32'h0000_3C3C)) begin
                    errors++;
                    $display("FAIL scrub_op%0d: we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                             i, mlog[i].we, mlog[i].addr, mlog[i].data, exp_we[i], exp_addr[i],
                             exp_we[i] ? 32'h0000_3C3C : 32'h0);
                end
            end
        end
        e1_mask[3] = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (mlog.size() != 6) begin
            errors++;
            $display("FAIL scrub_quiet: %0d memory ops after scrub_en drop, expected 6", mlog.size());
        end
    endtask

    task automatic test_hazard();
        int n;
        e1_mask[5] = 1'b1;
        mlog.delete();
        @(negedge clk);
        scrub_en = 1'b1;
        for (n = 0; n < 40 && mlog.size() == 0; n++) @(negedge clk);
        checks++;
        if (mlog.size() == 0 || mlog[0].we || mlog[0].addr != 5) begin
            errors++;
            $display("FAIL hazard_rd: ops=%0d first addr=%0d, expected scrub read of 5",
                     mlog.size(), mlog.size() ? mlog[0].addr : 99);
        end
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 4'd5; req_wdata = 32'h5555_AAAA;
        scrub_en = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL hazard_rdy: req_rdy=%b during scrub wait, expected 1", req_rdy);
        end
        @(negedge clk);
        req_vld = 1'b0;
        repeat (6) @(negedge clk);
        e1_mask[5] = 1'b0;
        checks++;
        if (mlog.size() != 2 || !mlog[1].we || mlog[1].addr != 5 || mlog[1].data !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL hazard_wb: %0d ops logged, expected 2 (scrub read 5, functional write 5 5555aaaa)",
                     mlog.size());
        end
        @(negedge clk);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'd5;
        @(negedge clk);
        req_vld = 1'b0;
        #1;
        checks++;
        if (rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL hazard_rsp_early: rsp_vld=%b one cycle after accept, expected 0", rsp_vld);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h5555_AAAA || rsp_err2b !== 1'b0) begin
            errors++;
            $display("FAIL hazard_readback: vld=%b rdata=%h err2b=%b, expected 1 5555aaaa 0",
                     rsp_vld, rsp_rdata, rsp_err2b);
        end
    endtask

    task automatic test_func_err2b();
        e2_mask[2] = 1'b1;
        @(negedge clk);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'd2;
        #1;
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL err2b_rdy: req_rdy=%b, expected 1", req_rdy);
        end
        @(negedge clk);
        req_vld = 1'b0;
        #1;
        checks++;
        if (rsp_vld !== 1'b0 || irq_err2b !== 1'b0) begin
            errors++;
            $display("FAIL err2b_early: rsp_vld=%b irq=%b, expected 0 0", rsp_vld, irq_err2b);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_vld !== 1'b1 || rsp_err2b !== 1'b1 || irq_err2b !== 1'b1) begin
            errors++;
            $display("FAIL err2b_rsp: rsp_vld=%b rsp_err2b=%b irq=%b, expected 1 1 1",
                     rsp_vld, rsp_err2b, irq_err2b);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_vld !== 1'b0 || irq_err2b !== 1'b0) begin
            errors++;
            $display("FAIL err2b_pulse: rsp_vld=%b irq=%b after pulse, expected 0 0", rsp_vld, irq_err2b);
        end
        e2_mask[2] = 1'b0;
    endtask

    task automatic test_starve();
        int acc = 0, stalls = 0, stall_idx = -1, rsp_cnt = 0;
        @(negedge clk);
        scrub_en = 1'b1;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'd1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_vld === 1'b1) rsp_cnt++;
            if (req_rdy === 1'b1) begin
                acc++;
            end else begin
                stalls++;
                if (stall_idx < 0) begin
                    stall_idx = c;
                    scrub_en = 1'b0;
                    checks++;
                    if (mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd6) begin
                        errors++;
                        $display("FAIL starve_port: ce=%b we=%b addr=%0d in stall cycle, expected scrub read of 6",
                                 mem_ce, mem_we, mem_addr);
                    end
                end
            end
            @(negedge clk);
        end
        req_vld = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (rsp_vld === 1'b1) rsp_cnt++;
            @(negedge clk);
        end
        checks++;
        if (stall_idx != 12 || stalls != 1) begin
            errors++;
            $display("FAIL starve_grant: first stall at cycle %0d with %0d stalls, expected cycle 12 with 1 stall",
                     stall_idx, stalls);
        end
        checks++;
        if (rsp_cnt != acc || acc != 19) begin
            errors++;
            $display("FAIL starve_rsp: %0d responses for %0d accepted reads, expected 19 and 19", rsp_cnt, acc);
        end
    endtask

    task automatic test_wrap_reset();
        int n, base;
        bit found = 0;
        e1_mask[15] = 1'b1;
        e2_mask[15] = 1'b1;
        mlog.delete();
        @(negedge clk);
        scrub_en = 1'b1;
        for (n = 0; n < 250 && !found; n++) begin
            @(negedge clk);
            if (mlog.size() > 0 && !mlog[$].we && mlog[$].addr == 15) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wrap_reach15: no scrub read of 15 in %0d cycles", n);
        end
        #1;
        checks++;
        if (irq_err2b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_irq_early: irq=%b, expected 0", irq_err2b);
        end
        @(negedge clk); #1;
        checks++;
        if (irq_err2b !== 1'b1 || rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL wrap_irq: irq=%b rsp_vld=%b on scrub err2b, expected 1 0", irq_err2b, rsp_vld);
        end
        @(negedge clk); #1;
        checks++;
        if (irq_err2b !== 1'b0) begin
            errors++;
            $display("FAIL wrap_irq_len: irq=%b, expected one-cycle pulse", irq_err2b);
        end
        e1_mask[15] = 1'b0;
        e2_mask[15] = 1'b0;
        base = mlog.size();
        for (n = 0; n < 40 && mlog.size() == base; n++) @(negedge clk);
        checks++;
        if (mlog.size() == base || mlog[base].we || mlog[base].addr != 0) begin
            errors++;
            $display("FAIL wrap_next: next op we=%b addr=%0d, expected scrub read of 0",
                     mlog.size() > base ? mlog[base].we : 1'b1, mlog.size() > base ? mlog[base].addr : 99);
        end
        // Now in the scrub wait; issue a functional read then reset before it returns.
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'd1;
        #1;
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL wrap_wait_rdy: req_rdy=%b in scrub wait, expected 1", req_rdy);
        end
        @(negedge clk);
        req_vld = 1'b0;
        scrub_en = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_vld !== 1'b0 || mem_ce !== 1'b0 || init_done !== 1'b0 || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: rsp_vld=%b ce=%b done=%b rdy=%b, expected all 0",
                     rsp_vld, mem_ce, init_done, req_rdy);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL midop_drop: rsp_vld=%b while in reset, expected 0", rsp_vld);
        end
        check_init_sweep("reinit");
    endtask

    initial begin
        rst = 1'b1;
        req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        scrub_en = 1'b0;
        e1_mask = '0; e2_mask = '0;
        test_reset();
        test_init();
        test_scrub_wb();
        test_hazard();
        test_func_err2b();
        test_starve();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
